// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO read side: FSM encoding,
// pointer widths and the binary-to-Gray helper.
package fifo_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 5;
   localparam int unsigned PTR_W          = DEF_ADDR_WIDTH + 1;
   // Widest pointer bin2gray handles; callers extend and truncate around it.
   localparam int unsigned MAX_PTR_W      = 16;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StArb  = 2'd1,
      StXfer = 2'd2
   } rd_state_e;

   function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request scanning upward
// from rr_last+1 with wrap-around.
module rr_arbiter #(
   parameter int unsigned N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req,
   input  logic [$clog2(N_REQ)-1:0] rr_last,
   output logic [N_REQ-1:0]         grant,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     valid
);

   localparam int unsigned IdW = $clog2(N_REQ);

   logic [IdW-1:0] idx;

   always_comb begin
      grant    = '0;
      grant_id = '0;
      valid    = 1'b0;
      idx      = '0;
      for (int unsigned i = 1; i <= N_REQ; i++) begin
         idx = IdW'((32'(rr_last) + i) % N_REQ);
         if (!valid && req[idx]) begin
            valid      = 1'b1;
            grant[idx] = 1'b1;
            grant_id   = idx;
         end
      end
   end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Read-side controller of the async FIFO: round-robin burst grants among
// N_REQ consumers, Rd_en generation and the binary/Gray read pointer.
module fifo_rd_arbiter
   import fifo_pkg::*;
#(
   parameter int unsigned Addr_width = DEF_ADDR_WIDTH,
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned MAX_BURST  = 8
) (
   input  logic                     Rd_clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         Req,
   input  logic [N_REQ-1:0]         Ready,
   input  logic                     Empty_sig,
   output logic                     Rd_en,
   output logic [N_REQ-1:0]         Grant,
   output logic [$clog2(N_REQ)-1:0] Grant_id,
   output logic                     Burst_done,
   output logic [Addr_width-1:0]    Rd_addr,
   output logic [Addr_width:0]      Rd_point
);

   localparam int unsigned IdW  = $clog2(N_REQ);
   localparam int unsigned PtrW = Addr_width + 1;
   localparam int unsigned CntW = $clog2(MAX_BURST) + 1;

   rd_state_e       state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [IdW-1:0]   grant_id_q, grant_id_d;
   logic [IdW-1:0]   rr_last_q, rr_last_d;
   logic [CntW-1:0]  burst_cnt_q, burst_cnt_d;
   logic             burst_done_q, burst_done_d;
   logic [PtrW-1:0]  ptr_bin_q, ptr_bin_d;
   logic [PtrW-1:0]  ptr_gray_q, ptr_gray_d;

   logic [N_REQ-1:0] arb_grant;
   logic [IdW-1:0]   arb_id;
   logic             arb_valid;

   rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_rr_arbiter (
      .req      (Req),
      .rr_last  (rr_last_q),
      .grant    (arb_grant),
      .grant_id (arb_id),
      .valid    (arb_valid)
   );

   always_ff @(posedge Rd_clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         grant_q      <= '0;
         grant_id_q   <= '0;
         rr_last_q    <= IdW'(N_REQ - 1);
         burst_cnt_q  <= '0;
         burst_done_q <= 1'b0;
         ptr_bin_q    <= '0;
         ptr_gray_q   <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         grant_id_q   <= grant_id_d;
         rr_last_q    <= rr_last_d;
         burst_cnt_q  <= burst_cnt_d;
         burst_done_q <= burst_done_d;
         ptr_bin_q    <= ptr_bin_d;
         ptr_gray_q   <= ptr_gray_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      grant_id_d   = grant_id_q;
      rr_last_d    = rr_last_q;
      burst_cnt_d  = burst_cnt_q;
      burst_done_d = 1'b0;
      ptr_bin_d    = ptr_bin_q;
      Rd_en        = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (|Req && !Empty_sig) state_d = StArb;
         end
         StArb: begin
            if (arb_valid) begin
               grant_d     = arb_grant;
               grant_id_d  = arb_id;
               burst_cnt_d = CntW'(MAX_BURST);
               state_d     = StXfer;
            end else begin
               state_d = StIdle;
            end
         end
         StXfer: begin
            Rd_en = Ready[grant_id_q] & Req[grant_id_q] & !Empty_sig;
            if (Rd_en) begin
               ptr_bin_d   = ptr_bin_q + 1'b1;
               burst_cnt_d = burst_cnt_q - 1'b1;
            end
            // Release on the last read of the burst or when the owner withdraws.
            if ((Rd_en && burst_cnt_q == CntW'(1)) || !Req[grant_id_q]) begin
               state_d      = StIdle;
               burst_done_d = 1'b1;
               rr_last_d    = grant_id_q;
               grant_d      = '0;
               grant_id_d   = '0;
            end
         end
         default: state_d = StIdle;
      endcase

      // Gray copy is registered with the binary pointer so Rd_point never glitches.
      ptr_gray_d = PtrW'(bin2gray(MAX_PTR_W'(ptr_bin_d)));
   end

   assign Grant      = grant_q;
   assign Grant_id   = grant_id_q;
   assign Burst_done = burst_done_q;
   assign Rd_addr    = ptr_bin_q[Addr_width-1:0];
   assign Rd_point   = ptr_gray_q;

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Directed bench for fifo_rd_arbiter: inputs change on the falling edge,
// outputs are checked 1 ns later against hand-derived expectations.
module tb_fifo_rd_arbiter;

   localparam int unsigned AW = 5;
   localparam int unsigned NR = 4;
   localparam int unsigned PW = AW + 1;

   logic          Rd_clk = 1'b0;
   logic          rst;
   logic [NR-1:0] Req;
   logic [NR-1:0] Ready;
   logic          Empty_sig;
   logic          Rd_en;
   logic [NR-1:0] Grant;
   logic [1:0]    Grant_id;
   logic          Burst_done;
   logic [AW-1:0] Rd_addr;
   logic [PW-1:0] Rd_point;

   int n_cmp = 0;
   int n_err = 0;
   logic [PW-1:0] ptr;

   always #5 Rd_clk = ~Rd_clk;

   fifo_rd_arbiter #(
      .Addr_width (AW),
      .N_REQ      (NR),
      .MAX_BURST  (8)
   ) dut (
      .Rd_clk     (Rd_clk),
      .rst        (rst),
      .Req        (Req),
      .Ready      (Ready),
      .Empty_sig  (Empty_sig),
      .Rd_en      (Rd_en),
      .Grant      (Grant),
      .Grant_id   (Grant_id),
      .Burst_done (Burst_done),
      .Rd_addr    (Rd_addr),
      .Rd_point   (Rd_point)
   );

   function automatic logic [PW-1:0] gray(input logic [PW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Cycle in XFER where a read must happen for requester g.
   task automatic read_cyc(input string tag, input int g);
      #1;
      check({tag, ".rd_en"}, 32'(Rd_en), 1);
      check({tag, ".grant"}, 32'(Grant), 32'(1 << g));
      check({tag, ".gid"}, 32'(Grant_id), 32'(g));
      check({tag, ".point"}, 32'(Rd_point), 32'(gray(ptr)));
      check({tag, ".addr"}, 32'(Rd_addr), 32'(ptr[AW-1:0]));
      ptr = ptr + 1'b1;
      @(negedge Rd_clk);
   endtask

   // Granted to g but no read this cycle.
   task automatic stall_cyc(input string tag, input int g);
      #1;
      check({tag, ".rd_en"}, 32'(Rd_en), 0);
      check({tag, ".grant"}, 32'(Grant), 32'(1 << g));
      check({tag, ".done"}, 32'(Burst_done), 0);
      @(negedge Rd_clk);
   endtask

   // IDLE or ARB cycle: no grant, no read; done as given.
   task automatic idle_cyc(input string tag, input int done);
      #1;
      check({tag, ".rd_en"}, 32'(Rd_en), 0);
      check({tag, ".grant"}, 32'(Grant), 0);
      check({tag, ".done"}, 32'(Burst_done), 32'(done));
      @(negedge Rd_clk);
   endtask

   initial begin
      rst       = 1'b0;
      Req       = 4'b1111;
      Ready     = 4'b1111;
      Empty_sig = 1'b0;
      ptr       = '0;

      // 1: held in reset with requests pending
      @(negedge Rd_clk);
      @(negedge Rd_clk);
      #1;
      check("t1.rst.rd_en", 32'(Rd_en), 0);
      check("t1.rst.grant", 32'(Grant), 0);
      check("t1.rst.gid", 32'(Grant_id), 0);
      check("t1.rst.done", 32'(Burst_done), 0);
      check("t1.rst.addr", 32'(Rd_addr), 0);
      check("t1.rst.point", 32'(Rd_point), 0);
      @(negedge Rd_clk);
      rst = 1'b1;
      idle_cyc("t1.c0", 0);
      idle_cyc("t1.c1", 0);

      // 2: all requesting, nine full bursts; pointer wraps 63 -> 0
      for (int g = 0; g < 9; g++) begin
         for (int k = 0; k < 8; k++) read_cyc("t2", g % 4);
         if (g == 8) Req = 4'b0000;
         idle_cyc("t2.done", 1);
         if (g != 8) idle_cyc("t2.arb", 0);
      end

      // 3: requester 2, FIFO empties after 3 reads
      Req = 4'b0100;
      idle_cyc("t3.idle", 0);
      idle_cyc("t3.arb", 0);
      for (int k = 0; k < 3; k++) read_cyc("t3", 2);
      Empty_sig = 1'b1;
      stall_cyc("t3.empty0", 2);
      stall_cyc("t3.empty1", 2);
      Empty_sig = 1'b0;
      for (int k = 0; k < 5; k++) read_cyc("t3.resume", 2);
      Req = 4'b0000;
      idle_cyc("t3.done", 1);

      // 4: requester 1 withdraws after 2 reads, requester 2 gets a fresh burst
      Req = 4'b0110;
      idle_cyc("t4.idle", 0);
      idle_cyc("t4.arb", 0);
      for (int k = 0; k < 2; k++) read_cyc("t4", 1);
      Req = 4'b0100;
      stall_cyc("t4.drop", 1);
      idle_cyc("t4.done", 1);
      idle_cyc("t4.arb2", 0);
      for (int k = 0; k < 8; k++) read_cyc("t4.next", 2);
      Req = 4'b0000;
      idle_cyc("t4.done2", 1);

      // 5: Ready toggling for requester 1
      Req = 4'b0010;
      idle_cyc("t5.idle", 0);
      idle_cyc("t5.arb", 0);
      for (int i = 0; i < 8; i++) begin
         Ready = (i % 2 == 0) ? 4'b1111 : 4'b0000;
         if (i % 2 == 0) read_cyc("t5", 1);
         else stall_cyc("t5.stall", 1);
      end
      Req   = 4'b0000;
      Ready = 4'b1111;
      #1;
      check("t5.addr", 32'(Rd_addr), 32'(ptr[AW-1:0]));
      stall_cyc("t5.rel", 1);
      idle_cyc("t5.done", 1);

      // 6: reset mid-burst of requester 2 after 5 reads
      Req = 4'b1111;
      idle_cyc("t6.idle", 0);
      idle_cyc("t6.arb", 0);
      for (int k = 0; k < 5; k++) read_cyc("t6", 2);
      rst = 1'b0;
      ptr = '0;
      #1;
      check("t6.rst.point", 32'(Rd_point), 0);
      check("t6.rst.grant", 32'(Grant), 0);
      check("t6.rst.gid", 32'(Grant_id), 0);
      check("t6.rst.rd_en", 32'(Rd_en), 0);
      check("t6.rst.addr", 32'(Rd_addr), 0);
      check("t6.rst.done", 32'(Burst_done), 0);
      @(negedge Rd_clk);
      #1;
      check("t6.rst.done2", 32'(Burst_done), 0);
      @(negedge Rd_clk);
      rst = 1'b1;
      idle_cyc("t6.c0", 0);
      idle_cyc("t6.c1", 0);
      read_cyc("t6.first", 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
